// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: valid/ready in, valid/ready out.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             err;

  modport master (
    output in_valid, opcode, a, b, out_ready,
    input  in_ready, out_valid, result, zero, err
  );

  modport slave (
    input  in_valid, opcode, a, b, out_ready,
    output in_ready, out_valid, result, zero, err
  );
endinterface

// File: rtl/alu_seq.sv
// Registered execute-stage ALU: single-cycle logic/shift/compare ops plus
// iterative shift-add multiply and restoring unsigned divide/remainder.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  alu_seq_if.slave  bus
);

  localparam int SHAMT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {K_MUL, K_DIVU, K_REMU} kind_t;

  state_t             state_q;
  kind_t              kind_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   x_q;
  logic [WIDTH-1:0]   y_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               err_q;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_err;
  logic [WIDTH-1:0]   mul_acc_d;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem_d;
  logic [WIDTH-1:0]   div_quo_d;
  logic [WIDTH-1:0]   iter_res;

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.result    = result_q;
    bus.zero      = zero_q;
    bus.err       = err_q;
  end

  always_comb begin
    shamt   = bus.b[SHAMT_W-1:0];
    alu_res = '0;
    alu_err = 1'b0;
    case (bus.opcode)
      4'd0:  alu_res = bus.a + bus.b;
      4'd1:  alu_res = bus.a - bus.b;
      4'd2:  alu_res = bus.a & bus.b;
      4'd3:  alu_res = bus.a | bus.b;
      4'd4:  alu_res = bus.a ^ bus.b;
      4'd5:  alu_res = bus.a << shamt;
      4'd6:  alu_res = bus.a >> shamt;
      4'd7:  alu_res = $signed(bus.a) >>> shamt;
      4'd8:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      4'd9:  alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      4'd10, 4'd11, 4'd12: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  // acc_q doubles as product accumulator (MUL) or partial remainder (DIV/REM);
  // x_q is the shifting multiplicand or fixed divisor, y_q the shifting
  // multiplier or dividend/quotient.
  always_comb begin
    mul_acc_d = y_q[0] ? (acc_q + x_q) : acc_q;
    div_sh    = {acc_q, y_q[WIDTH-1]};
    div_trial = div_sh - {1'b0, x_q};
    div_ge    = ~div_trial[WIDTH];
    div_rem_d = div_ge ? div_trial[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_quo_d = {y_q[WIDTH-2:0], div_ge};
    case (kind_q)
      K_MUL:   iter_res = mul_acc_d;
      K_DIVU:  iter_res = div_quo_d;
      default: iter_res = div_rem_d;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      kind_q   <= K_MUL;
      cnt_q    <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            case (bus.opcode)
              4'd10: begin
                kind_q  <= K_MUL;
                acc_q   <= '0;
                x_q     <= bus.a;
                y_q     <= bus.b;
                cnt_q   <= '1;
                state_q <= BUSY;
              end
              4'd11, 4'd12: begin
                if (bus.b == '0) begin
                  result_q <= (bus.opcode == 4'd11) ? '1 : bus.a;
                  zero_q   <= (bus.opcode == 4'd11) ? 1'b0 : (bus.a == '0);
                  err_q    <= 1'b1;
                  state_q  <= DONE;
                end else begin
                  kind_q  <= (bus.opcode == 4'd11) ? K_DIVU : K_REMU;
                  acc_q   <= '0;
                  x_q     <= bus.b;
                  y_q     <= bus.a;
                  cnt_q   <= '1;
                  state_q <= BUSY;
                end
              end
              default: begin
                result_q <= alu_res;
                zero_q   <= (alu_res == '0);
                err_q    <= alu_err;
                state_q  <= DONE;
              end
            endcase
          end
        end
        BUSY: begin
          if (kind_q == K_MUL) begin
            acc_q <= mul_acc_d;
            x_q   <= x_q << 1;
            y_q   <= y_q >> 1;
          end else begin
            acc_q <= div_rem_d;
            y_q   <= div_quo_d;
          end
          if (cnt_q == '0) begin
            result_q <= iter_res;
            zero_q   <= (iter_res == '0);
            err_q    <= 1'b0;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH = 32).
module tb_alu_seq;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   lat;

  alu_seq_if #(.WIDTH(32)) bus ();

  alu_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents an op, checks it is accepted on the next edge, then scrambles inputs.
  task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
    bus.opcode   = op;
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    chk("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.opcode   = 4'd3;
    bus.a        = 32'hDEAD_BEEF;
    bus.b        = 32'h0000_0001;
  endtask

  task automatic wait_out(input string tag, output int l);
    l = 1;
    while (!bus.out_valid && l < 200) begin
      @(posedge clk);
      #1;
      l++;
    end
    chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic expect_out(input string tag, input logic [31:0] r, input logic z,
                            input logic e, input int lat_exp);
    int l;
    wait_out(tag, l);
    chk({tag, ".result"}, bus.result, r);
    chk({tag, ".zero"}, {31'd0, bus.zero}, {31'd0, z});
    chk({tag, ".err"}, {31'd0, bus.err}, {31'd0, e});
    chk({tag, ".latency"}, l, lat_exp);
    if (bus.out_ready) begin
      @(posedge clk);
      #1;
      chk({tag, ".released"}, {31'd0, bus.out_valid}, 32'd0);
    end
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.opcode    = 4'd0;
    bus.a         = '0;
    bus.b         = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.result", bus.result, 32'd0);
    chk("rst.zero", {31'd0, bus.zero}, 32'd0);
    chk("rst.err", {31'd0, bus.err}, 32'd0);
    reset = 1'b0;

    // Idle with in_valid low: nothing happens.
    repeat (3) @(posedge clk);
    #1;
    chk("idle.out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Reset mid-MUL discards the operation.
    issue(4'd10, 32'd7, 32'd6);
    repeat (9) @(posedge clk);
    #1;
    chk("midmul.busy", {31'd0, bus.in_ready}, 32'd0);
    reset = 1'b1;
    #1;
    chk("midmul.rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midmul.in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("midmul.out_valid", {31'd0, bus.out_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("midmul.no_output", {31'd0, bus.out_valid}, 32'd0);
    issue(4'd0, 32'd2, 32'd3);
    expect_out("add_after_rst", 32'd5, 1'b0, 1'b0, 1);

    // Single-cycle sweep.
    issue(4'd0, 32'hFFFF_FFFF, 32'd1);
    expect_out("add_wrap", 32'd0, 1'b1, 1'b0, 1);
    issue(4'd1, 32'd3, 32'd5);
    expect_out("sub", 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
    issue(4'd2, 32'hF0F0, 32'hFF00);
    expect_out("and", 32'hF000, 1'b0, 1'b0, 1);
    issue(4'd3, 32'hF0F0, 32'h0F0F);
    expect_out("or", 32'hFFFF, 1'b0, 1'b0, 1);
    issue(4'd4, 32'hAAAA_5555, 32'hFFFF_FFFF);
    expect_out("xor", 32'h5555_AAAA, 1'b0, 1'b0, 1);
    issue(4'd5, 32'd1, 32'd36);
    expect_out("sll", 32'h10, 1'b0, 1'b0, 1);
    issue(4'd6, 32'h8000_0000, 32'd31);
    expect_out("srl", 32'd1, 1'b0, 1'b0, 1);
    issue(4'd7, 32'h8000_0000, 32'd35);
    expect_out("sra", 32'hF000_0000, 1'b0, 1'b0, 1);
    issue(4'd8, 32'hFFFF_FFFF, 32'd1);
    expect_out("slt", 32'd1, 1'b0, 1'b0, 1);
    issue(4'd9, 32'hFFFF_FFFF, 32'd1);
    expect_out("sltu", 32'd0, 1'b1, 1'b0, 1);

    // Multiply.
    issue(4'd10, 32'h1_0000, 32'h1_0000);
    expect_out("mul_wrap", 32'd0, 1'b1, 1'b0, 33);
    issue(4'd10, 32'd7, 32'd6);
    expect_out("mul_7x6", 32'd42, 1'b0, 1'b0, 33);
    issue(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_out("mul_max", 32'd1, 1'b0, 1'b0, 33);

    // Divide / remainder.
    issue(4'd11, 32'd100, 32'd7);
    expect_out("divu", 32'd14, 1'b0, 1'b0, 33);
    issue(4'd12, 32'd100, 32'd7);
    expect_out("remu", 32'd2, 1'b0, 1'b0, 33);
    issue(4'd11, 32'hFFFF_FFFF, 32'h10);
    expect_out("divu_max", 32'h0FFF_FFFF, 1'b0, 1'b0, 33);
    issue(4'd12, 32'hFFFF_FFFF, 32'h10);
    expect_out("remu_max", 32'hF, 1'b0, 1'b0, 33);
    issue(4'd11, 32'd5, 32'd0);
    expect_out("divu_by0", 32'hFFFF_FFFF, 1'b0, 1'b1, 1);
    issue(4'd12, 32'd5, 32'd0);
    expect_out("remu_by0", 32'd5, 1'b0, 1'b1, 1);

    // Illegal opcode then a legal op clears err.
    issue(4'd14, 32'd9, 32'd9);
    expect_out("illegal", 32'd0, 1'b1, 1'b1, 1);
    issue(4'd2, 32'hF0F0, 32'hFF00);
    expect_out("and_after_illegal", 32'hF000, 1'b0, 1'b0, 1);

    // Back-pressure: result held, new op waits until the slot frees.
    bus.out_ready = 1'b0;
    issue(4'd0, 32'h10, 32'h20);
    expect_out("bp", 32'h30, 1'b0, 1'b0, 1);
    bus.opcode   = 4'd1;
    bus.a        = 32'd9;
    bus.b        = 32'd4;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp.hold_result", bus.result, 32'h30);
      chk("bp.hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp.in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp.release_idle", {31'd0, bus.in_ready}, 32'd1);
    chk("bp.release_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    expect_out("bp_next_sub", 32'd5, 1'b0, 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational CPU ALU. Adds the full shift/compare set and iterative multiply and unsigned divide/remainder.
- Operands enter through a valid/ready input handshake. Results leave through a valid/ready output handshake.
- Sits in the execute stage. It can stall the pipeline while multi-cycle ops run.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, ≥ 8.
- SHAMT_W, $clog2(WIDTH), shift-amount bits taken from b (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  opcode/a/b are valid this cycle.
- in_ready  output  1  block can accept an operation.
- opcode  input  4  operation select (map below).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result/zero/err are valid.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  operation result.
- zero  output  1  high when result == 0.
- err  output  1  illegal opcode (13–15) or divide by zero.

Behaviour:
- Opcode map:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift by b[SHAMT_W-1:0].
  - 8 SLT (signed), 9 SLTU; result 1 or 0, zero-extended.
  - 10 MUL: low WIDTH bits of the product.
  - 11 DIVU, 12 REMU.
  - 13–15 illegal.
- Wrap-around: ADD/SUB/MUL wrap modulo 2^WIDTH. No carry or overflow output.
- Accept: an operation is accepted on any rising edge with in_valid && in_ready.
- in_ready = (state == IDLE). It is combinational from state only, never from in_valid.
- Operands are captured at accept. Input changes after accept have no effect.
- FSM states and transitions:
  - IDLE: accept of opcode 0–9 or 13–15 → DONE on the next edge. Accept of 10–12 → BUSY, with cnt = WIDTH-1.
  - BUSY: one iteration per cycle; cnt decrements. When cnt == 0 and the iteration completes → DONE.
  - DONE: out_valid = 1. On out_valid && out_ready → IDLE.
- Latency (accept edge = cycle 0):
  - Single-cycle ops: out_valid high from cycle 1.
  - MUL/DIVU/REMU: out_valid high from cycle WIDTH+1, i.e. 33 for WIDTH=32.
- Throughput: at most one op per 2 cycles. in_ready is low in DONE, even while out_ready is high.
- MUL: shift-add, LSB-first over b. The accumulator is WIDTH bits (high bits discarded).
- DIVU/REMU: restoring division, MSB-first. Quotient and remainder registers are each WIDTH bits.
- Divide by zero (b == 0), decided at accept:
  - DIVU result = all ones; REMU result = a; err = 1.
  - Goes directly to DONE with 1-cycle latency.
- Illegal opcodes: result = 0, zero = 1, err = 1.
- Output stability: result, zero and err are registered. They must not change while out_valid && !out_ready.
- Outputs outside DONE: result, zero and err hold their last values and are don't-care to consumers.
- Reset (any state, including mid-BUSY):
  - state = IDLE; in_ready = 1 after reset deasserts.
  - out_valid = 0, result = 0, zero = 0, err = 0, cnt = 0.
  - Any in-flight operation is discarded with no output.
- Simultaneous in_valid with out_valid/DONE: not accepted (in_ready = 0). The upstream must hold in_valid.
- in_valid low in IDLE: nothing changes.

Test Plan:
- Reset mid-MUL: accept MUL, assert reset at cycle 10 → out_valid = 0 and in_ready = 1 on release. The next ADD 2+3 gives result = 5 at cycle 1.
- ALU sweep, one op per 2 cycles with out_ready = 1:
  - ADD 0xFFFFFFFF+1 → 0, zero = 1.
  - SUB 3−5 → 0xFFFFFFFE.
  - SRA 0x80000000 by 35 (shamt 3) → 0xF0000000.
  - SLT 0xFFFFFFFF,1 → 1; SLTU same operands → 0.
- MUL 0x10000,0x10000 → result = 0 (wrap), zero = 1, out_valid exactly at cycle 33. MUL 7×6 → 42.
- Division:
  - DIVU 100/7 → 14; REMU 100/7 → 2; both at cycle 33.
  - DIVU 5/0 → 0xFFFFFFFF, err = 1, at cycle 1. REMU 5/0 → 5, err = 1.
- Back-pressure: hold out_ready = 0 for 5 cycles after out_valid → result stable, in_ready = 0. Raise out_ready → IDLE on the next edge; a new op is accepted the cycle after.
- Illegal opcode 14 → result = 0, zero = 1, err = 1 at cycle 1. A following AND 0xF0F0,0xFF00 → 0xF000 with err = 0.
